// File: rtl/psram_access_arbiter_if.sv
// Bundle between the two frame requesters, the arbiter and the PSRAM controller port.
// Handshake: a requester holds rq high until its burst is finished; ack is a one-cycle grant coinciding with mem_cmd_en.
interface psram_access_arbiter_if;
  logic        calib_done;
  logic        wr_rq;
  logic [20:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        wr_data_rd;
  logic        rd_rq;
  logic [20:0] rd_addr;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic        mem_cmd;
  logic        mem_cmd_en;
  logic [20:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;
  logic        mem_rd_data_valid;
  logic        busy;
  logic        err;

  modport master (
    input  calib_done, wr_rq, wr_addr, wr_data, rd_rq, rd_addr,
           mem_rd_data, mem_rd_data_valid,
    output wr_ack, wr_data_rd, rd_ack, rd_data, rd_data_valid,
           mem_cmd, mem_cmd_en, mem_addr, mem_wr_data, busy, err
  );

  modport slave (
    output calib_done, wr_rq, wr_addr, wr_data, rd_rq, rd_addr,
           mem_rd_data, mem_rd_data_valid,
    input  wr_ack, wr_data_rd, rd_ack, rd_data, rd_data_valid,
           mem_cmd, mem_cmd_en, mem_addr, mem_wr_data, busy, err
  );
endinterface

// File: rtl/psram_access_arbiter.sv
// Shares one PSRAM controller port between the camera writer and the display reader.
// Writes win arbitration, but only MAX_WR_STREAK times in a row while a read is waiting.
module psram_access_arbiter #(
  parameter int MEMORY_BURST  = 32,
  parameter int CMD_GAP       = 14,
  parameter int MAX_WR_STREAK = 4,
  parameter int RD_TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  psram_access_arbiter_if.master bus,
  output logic [2:0]            state_dbg_o
);

  localparam int BURST_CYCLES = MEMORY_BURST / 4;
  localparam int BW = $clog2(BURST_CYCLES + 1);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam int GW = $clog2(CMD_GAP + 1);
  localparam int SW = $clog2(MAX_WR_STREAK + 1);

  localparam logic [BW-1:0] BEATS      = BW'(BURST_CYCLES);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(BURST_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(RD_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(CMD_GAP - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_WR_STREAK);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB     = 3'd1,
    CMD     = 3'd2,
    WR_DATA = 3'd3,
    RD_DATA = 3'd4,
    RELEASE = 3'd5,
    GAP     = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [20:0]   addr_q, addr_d;
  logic          gw_q, gw_d;
  logic          err_q, err_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      streak_q <= '0;
      beat_q   <= '0;
      tmo_q    <= '0;
      gap_q    <= '0;
      addr_q   <= '0;
      gw_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      beat_q   <= beat_d;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
      addr_q   <= addr_d;
      gw_q     <= gw_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    beat_d   = beat_q;
    tmo_d    = tmo_q;
    gap_d    = gap_q;
    addr_d   = addr_q;
    gw_d     = gw_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (bus.calib_done) state_d = ARB;
      ARB: begin
        if (!bus.calib_done) begin
          state_d = IDLE;
        end else if (bus.wr_rq && (!bus.rd_rq || streak_q < STREAK_MAX)) begin
          gw_d     = 1'b1;
          addr_d   = bus.wr_addr;
          streak_d = (streak_q < STREAK_MAX) ? streak_q + SW'(1) : streak_q;
          state_d  = CMD;
        end else if (bus.rd_rq) begin
          gw_d     = 1'b0;
          addr_d   = bus.rd_addr;
          streak_d = '0;
          state_d  = CMD;
        end
      end
      CMD: begin
        if (gw_q) begin
          beat_d  = BW'(1);
          state_d = WR_DATA;
        end else begin
          beat_d  = '0;
          tmo_d   = '0;
          state_d = RD_DATA;
        end
      end
      // The cycle with beat_q == BEATS is the idle tail after the last word.
      WR_DATA: begin
        if (beat_q == BEATS) state_d = RELEASE;
        else                 beat_d  = beat_q + BW'(1);
      end
      // A final beat landing on the timeout cycle still counts as a complete burst.
      RD_DATA: begin
        if (bus.mem_rd_data_valid) beat_d = beat_q + BW'(1);
        if (bus.mem_rd_data_valid && beat_q == BEAT_LAST) begin
          state_d = RELEASE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RELEASE: begin
        if (!(gw_q ? bus.wr_rq : bus.rd_rq)) begin
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = ARB;
        else                   gap_d   = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  logic in_cmd, busy;
  assign in_cmd = (state_q == CMD);
  assign busy   = (state_q != IDLE) && (state_q != ARB);

  assign bus.mem_cmd_en    = in_cmd;
  assign bus.mem_cmd       = gw_q;
  assign bus.mem_addr      = addr_q;
  assign bus.wr_ack        = in_cmd && gw_q;
  assign bus.rd_ack        = in_cmd && !gw_q;
  assign bus.wr_data_rd    = (in_cmd && gw_q) || (state_q == WR_DATA && beat_q != BEATS);
  assign bus.mem_wr_data   = (gw_q && busy) ? bus.wr_data : 32'd0;
  assign bus.rd_data       = bus.mem_rd_data;
  assign bus.rd_data_valid = bus.mem_rd_data_valid && (state_q == RD_DATA) && !gw_q;
  assign bus.busy          = busy;
  assign bus.err           = err_q;
  assign state_dbg_o       = state_q;

endmodule

// File: doc/psram_access_arbiter.md
Name: psram_access_arbiter

Overview:
- Shares the single PSRAM controller command/data port between two requesters:
  - the camera frame writer (write requester);
  - the display frame downloader (read requester).
- Sequences each burst: grant, command pulse, data beats, release, command gap.
- Sits between the requesters' rq/ack handshakes and the Gowin PSRAM controller.
- Write side has priority, with a streak limit so reads are never starved.

Parameters:
MEMORY_BURST, 32, burst length in bytes; BURST_CYCLES = MEMORY_BURST/4 data beats of 32 bits (8 at default)
CMD_GAP, 14, idle cycles enforced between the end of one transaction and the next command
MAX_WR_STREAK, 4, consecutive write grants allowed while rd_rq is pending
RD_TIMEOUT, 255, cycles after mem_cmd_en within which all read beats must arrive

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
calib_done  in  1  PSRAM controller calibration complete
wr_rq  in  1  write request; held high until transaction finished
wr_addr  in  21  write burst address; sampled at grant
wr_data  in  32  current write word
wr_ack  out  1  one-cycle grant pulse to writer
wr_data_rd  out  1  writer must advance to next word on the following cycle
rd_rq  in  1  read request; held high until all beats received
rd_addr  in  21  read burst address; sampled at grant
rd_ack  out  1  one-cycle grant pulse to reader
rd_data  out  32  mem_rd_data forwarded
rd_data_valid  out  1  mem_rd_data_valid gated by active read
mem_cmd  out  1  1=write, 0=read
mem_cmd_en  out  1  command strobe
mem_addr  out  21  command address
mem_wr_data  out  32  wr_data forwarded
mem_rd_data  in  32  PSRAM read data
mem_rd_data_valid  in  1  PSRAM read beat valid
busy  out  1  high in every state except IDLE/ARB
err  out  1  sticky read-timeout flag; cleared only by reset

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE, streak=0, counters 0.
- Reset mid-transaction aborts immediately and drops mem_cmd_en.
- States:
  - IDLE:
    - Waits for calib_done=1, then goes to ARB.
  - ARB (checks calib_done each cycle; low → IDLE):
    - Write is granted if wr_rq && (!rd_rq || streak<MAX_WR_STREAK).
    - Otherwise read is granted if rd_rq.
    - On grant: latch the granted address into mem_addr and set grant_is_write, then go to CMD.
    - Streak update:
      - write grant: streak+1, saturating at MAX_WR_STREAK;
      - read grant: streak=0.
    - No request: stay in ARB.
  - CMD (exactly 1 cycle):
    - mem_cmd_en=1, mem_cmd=grant_is_write, granted ack=1.
    - Write: wr_data_rd=1 (beat 0), beat_cnt=1, go to WR_DATA.
    - Read: beat_cnt=0, tmo_cnt=0, go to RD_DATA.
  - WR_DATA:
    - wr_data_rd=1 each cycle; beat_cnt increments.
    - When beat_cnt==BURST_CYCLES, wr_data_rd=0 and go to RELEASE.
    - Exactly BURST_CYCLES consecutive wr_data_rd cycles per write, counting the CMD cycle.
  - RD_DATA:
    - Each mem_rd_data_valid increments beat_cnt.
    - At BURST_CYCLES beats, go to RELEASE.
    - tmo_cnt increments each cycle; at RD_TIMEOUT set err=1 and go to RELEASE.
  - RELEASE:
    - Waits until the granted rq is low, then goes to GAP with gap_cnt=0.
  - GAP:
    - Runs CMD_GAP cycles, then goes to ARB.
- mem_wr_data = wr_data combinationally, whenever a write is granted; otherwise 0.
- rd_data passes through unconditionally.
- rd_data_valid = mem_rd_data_valid only in RD_DATA with a read granted; otherwise 0.
- Stray valid beats in any other state are ignored.
- Request rules:
  - rq is sampled only in ARB.
  - Once granted, a transaction always completes; a requester dropping rq early does not cancel it.
  - Dropping rq early only shortens RELEASE.
- mem_cmd_en is never asserted closer than CMD_GAP+2 cycles after the previous transaction's last beat.
- Simultaneous wr_rq and rd_rq in ARB follow the priority/streak rule above.

Test Plan:
1. calib_done=0 with wr_rq=1 → no mem_cmd_en and no wr_ack. Raise calib_done → ARB, then CMD two cycles later: mem_cmd_en=1, mem_cmd=1, mem_addr=wr_addr (0x01234), wr_ack pulse, 8 consecutive wr_data_rd.
2. Read at rd_addr=0x0A000, memory model returns 8 valid beats after 6-cycle latency → rd_ack pulse 1 cycle, mem_cmd=0, rd_data_valid exactly 8 cycles with data matching. Hold rd_rq for 3 more cycles → next mem_cmd_en no earlier than CMD_GAP+2 cycles after rq drop/last beat.
3. wr_rq and rd_rq both held continuously → grant order W,W,W,W,R,W,W,W,W,R; streak resets after each read.
4. Read with model returning only 5 beats → err=1 after 255 cycles, state returns to ARB, next write serviced normally. err stays 1 until reset.
5. mem_rd_data_valid pulses during WR_DATA and GAP → rd_data_valid stays 0.
6. Assert reset_n=0 during beat 3 of WR_DATA → all outputs 0 asynchronously. After release, no command is issued before calib_done and a fresh request.
